// File: rtl/slow_packer_pkg.sv
// Shared types, default parameter values and the packed-word formatter for the slow packer.
package slow_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE
  } eng_state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ORB_W     = 12;
  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_FRAME_LEN = 20;
  localparam int DEF_NCH       = 2;
  localparam int DEF_FIRST_POS = 16;
  localparam int DEF_WE_DELAY  = 30;
  localparam int DEF_WE_LEN    = 2;
  localparam int DEF_QDEPTH    = 2;

  // {0, hi, top (orb_w-data_w-2) bits of lo, 0}; hi must arrive zero-extended.
  function automatic logic [63:0] fmt_word(input logic [63:0] hi, input logic [63:0] lo,
                                           input int data_w, input int orb_w);
    int lw;
    logic [63:0] lo_top;
    lw     = orb_w - data_w - 2;
    lo_top = (lo >> (data_w - lw)) & ((64'd1 << lw) - 64'd1);
    return (hi << (lw + 1)) | (lo_top << 1);
  endfunction

endpackage

// File: rtl/slow_wr_fifo.sv
// Small write queue; a push into a full queue is still taken when a pop happens in the same clock.
module slow_wr_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/slow_packer_mc.sv
// Packs strobed byte pairs into RAM words and writes them out with a slow settle/strobe handshake.
module slow_packer_mc
  import slow_packer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ORB_W     = DEF_ORB_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int NCH       = DEF_NCH,
  parameter int FIRST_POS = DEF_FIRST_POS,
  parameter int WE_DELAY  = DEF_WE_DELAY,
  parameter int WE_LEN    = DEF_WE_LEN,
  parameter int QDEPTH    = DEF_QDEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] addr_ram_i,
  input  logic              strob_i,
  input  logic              sw_i,
  output logic [ORB_W-1:0]  orb_word_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              we_o,
  output logic              resync_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam int PW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int QW    = ORB_W + ADDR_W;
  localparam int CNT_W = 16;

  logic strb_s1, strb_s2, strb_s3;
  logic sw_s1, sw_s2, sw_ref;
  logic byte_evt, resync_evt;

  logic [PW-1:0]     pos, eff_pos;
  logic [DATA_W-1:0] hi [NCH];
  logic              pend;
  logic [ORB_W-1:0]  pend_word;
  logic [ADDR_W-1:0] pend_addr;

  logic              fifo_full, fifo_empty, pop;
  logic [QW-1:0]     fifo_rdata;

  eng_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strb_s1 <= 1'b0;
      strb_s2 <= 1'b0;
      strb_s3 <= 1'b0;
      sw_s1   <= 1'b0;
      sw_s2   <= 1'b0;
      sw_ref  <= 1'b0;
    end else begin
      strb_s1 <= strob_i;
      strb_s2 <= strb_s1;
      strb_s3 <= strb_s2;
      sw_s1   <= sw_i;
      sw_s2   <= sw_s1;
      sw_ref  <= sw_s2;
    end
  end

  assign byte_evt   = strb_s2 && !strb_s3;
  assign resync_evt = sw_s2 ^ sw_ref;
  assign resync_o   = resync_evt;
  // A resync landing on a byte edge puts that byte at position 0.
  assign eff_pos    = resync_evt ? '0 : pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos       <= '0;
      pend      <= 1'b0;
      pend_word <= '0;
      pend_addr <= '0;
      for (int c = 0; c < NCH; c++) hi[c] <= '0;
    end else begin
      pend <= 1'b0;
      if (resync_evt) begin
        for (int c = 0; c < NCH; c++) hi[c] <= '0;
      end
      if (byte_evt) begin
        pos <= (eff_pos == PW'(FRAME_LEN - 1)) ? '0 : eff_pos + 1'b1;
        for (int c = 0; c < NCH; c++) begin
          if (eff_pos == PW'(FIRST_POS + 2*c)) hi[c] <= data_i;
          if (eff_pos == PW'(FIRST_POS + 2*c + 1)) begin
            pend      <= 1'b1;
            pend_word <= ORB_W'(fmt_word(64'(resync_evt ? {DATA_W{1'b0}} : hi[c]),
                                         64'(data_i), DATA_W, ORB_W));
            pend_addr <= addr_ram_i;
          end
        end
      end else if (resync_evt) begin
        pos <= '0;
      end
    end
  end

  slow_wr_fifo #(
    .WIDTH(QW),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend),
    .pop  (pop),
    .wdata({pend_word, pend_addr}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_o <= 1'b0;
    end else if (pend && fifo_full && !pop) begin
      overflow_o <= 1'b1;
    end else if (resync_evt) begin
      overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      orb_word_o <= '0;
      wr_addr_o  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (pop) {orb_word_o, wr_addr_o} <= fifo_rdata;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_SETTLE;
          cnt_n   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(WE_DELAY - 1)) begin
          state_n = ST_STROBE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt == CNT_W'(WE_LEN - 1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign we_o   = (state == ST_STROBE);
  assign busy_o = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_slow_packer_mc.sv
// Scoreboard bench: a default-parameter packer plus a short-frame copy used to provoke queue overflow.
module tb_slow_packer_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dataIn;
  logic [10:0] addrIn;
  logic        strob, sw, strob2, sw2;
  logic [11:0] orbWord, orbWord2;
  logic [10:0] wrAddr, wrAddr2;
  logic        we, resync, overflow, busy;
  logic        we2, resync2, overflow2, busy2;

  typedef struct {
    logic [11:0] word;
    logic [10:0] addr;
    int          start;
  } exp_t;

  exp_t expQ[$];
  exp_t expQ2[$];
  exp_t head, head2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastE = 0;
  int   nextLoad = 0;
  int   resyncCount = 0;
  int   runLen = 0;
  logic wePrev = 1'b0;
  logic we2Prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  slow_packer_mc u_dut (
    .clk(clk), .rst(rst), .data_i(dataIn), .addr_ram_i(addrIn),
    .strob_i(strob), .sw_i(sw),
    .orb_word_o(orbWord), .wr_addr_o(wrAddr), .we_o(we),
    .resync_o(resync), .overflow_o(overflow), .busy_o(busy)
  );

  slow_packer_mc #(.FRAME_LEN(4), .FIRST_POS(0)) u_small (
    .clk(clk), .rst(rst), .data_i(dataIn), .addr_ram_i(addrIn),
    .strob_i(strob2), .sw_i(sw2),
    .orb_word_o(orbWord2), .wr_addr_o(wrAddr2), .we_o(we2),
    .resync_o(resync2), .overflow_o(overflow2), .busy_o(busy2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One byte strobe, called at a negedge; the byte is sampled three clocks later.
  task automatic applyStimulus(input bit toSmall, input logic [7:0] d, input logic [10:0] a);
    dataIn = d;
    addrIn = a;
    if (toSmall) strob2 = 1'b1; else strob = 1'b1;
    lastE = cyc + 3;
    repeat (2) @(negedge clk);
    if (toSmall) strob2 = 1'b0; else strob = 1'b0;
    repeat (toSmall ? 2 : 4) @(negedge clk);
  endtask

  task automatic expectWrite(input logic [11:0] w, input logic [10:0] a);
    int load;
    load = (lastE + 2 > nextLoad) ? lastE + 2 : nextLoad;
    nextLoad = load + 33;
    expQ.push_back('{word: w, addr: a, start: load + 30});
  endtask

  task automatic waitIdle(input bit toSmall, input int budget);
    int n = 0;
    while ((toSmall ? busy2 : busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(toSmall ? "small_idle_timeout" : "idle_timeout", 32'(n >= budget), 32'd0);
  endtask

  always @(negedge clk) begin
    if (we && !wePrev) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got word 0x%0h, expected no write", orbWord);
      end else begin
        head = expQ.pop_front();
        checkOutput("word", 32'(orbWord), 32'(head.word));
        checkOutput("addr", 32'(wrAddr), 32'(head.addr));
        checkOutput("we_start", 32'(cyc), 32'(head.start));
      end
      runLen = 1;
    end else if (we) begin
      runLen++;
    end else if (wePrev) begin
      checkOutput("we_len", 32'(runLen), 32'd2);
    end
    if (resync) resyncCount++;
    wePrev = we;
  end

  always @(negedge clk) begin
    if (we2 && !we2Prev) begin
      if (expQ2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL small_unexpected_write: got word 0x%0h, expected no write", orbWord2);
      end else begin
        head2 = expQ2.pop_front();
        checkOutput("small_word", 32'(orbWord2), 32'(head2.word));
        checkOutput("small_addr", 32'(wrAddr2), 32'(head2.addr));
      end
    end
    we2Prev = we2;
  end

  initial begin
    rst = 1'b0; strob = 1'b0; sw = 1'b0; strob2 = 1'b0; sw2 = 1'b0;
    dataIn = '0; addrIn = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_word", 32'(orbWord), 32'h0);
    checkOutput("rst_addr", 32'(wrAddr), 32'h0);
    checkOutput("rst_we", 32'(we), 32'h0);
    checkOutput("rst_resync", 32'(resync), 32'h0);
    checkOutput("rst_overflow", 32'(overflow), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Short frame: four words back to back while the first write settles; the fourth is dropped.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 8'(8'h11 * (k + 1)), 11'(k / 2 + 1));
      if (k == 1) expQ2.push_back('{word: 12'h088, addr: 11'd1, start: 0});
      if (k == 3) expQ2.push_back('{word: 12'h19A, addr: 11'd2, start: 0});
      if (k == 5) expQ2.push_back('{word: 12'h2AA, addr: 11'd3, start: 0});
    end
    repeat (2) @(negedge clk);
    checkOutput("small_overflow_set", 32'(overflow2), 32'd1);
    waitIdle(1'b1, 300);
    checkOutput("small_overflow_sticky", 32'(overflow2), 32'd1);
    checkOutput("small_queue_drained", 32'(expQ2.size()), 32'd0);
    sw2 = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("small_overflow_cleared", 32'(overflow2), 32'd0);

    // Channel 0 at 16/17, channel 1 at 18/19 arriving during the first settle.
    for (int p = 0; p < 20; p++) begin
      case (p)
        16: applyStimulus(1'b0, 8'hA5, 11'h000);
        17: begin applyStimulus(1'b0, 8'hC3, 11'h155); expectWrite(12'h52E, 11'h155); end
        18: applyStimulus(1'b0, 8'h12, 11'h000);
        19: begin applyStimulus(1'b0, 8'h40, 11'h2AA); expectWrite(12'h092, 11'h2AA); end
        default: applyStimulus(1'b0, 8'(p), 11'h000);
      endcase
    end
    waitIdle(1'b0, 300);
    checkOutput("overflow_clear", 32'(overflow), 32'd0);
    checkOutput("queue_drained_1", 32'(expQ.size()), 32'd0);

    // Resync after position 9 restarts the frame.
    for (int p = 0; p < 10; p++) applyStimulus(1'b0, 8'(p), 11'h000);
    sw = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("resync_pulses_1", 32'(resyncCount), 32'd1);
    for (int p = 0; p < 18; p++) begin
      if (p == 16) applyStimulus(1'b0, 8'h80, 11'h000);
      else if (p == 17) begin applyStimulus(1'b0, 8'hFF, 11'h001); expectWrite(12'h406, 11'h001); end
      else applyStimulus(1'b0, 8'(p), 11'h000);
    end
    waitIdle(1'b0, 300);
    checkOutput("queue_drained_2", 32'(expQ.size()), 32'd0);

    // Resync and strobe together: that byte is position 0.
    sw = 1'b0;
    applyStimulus(1'b0, 8'hEE, 11'h000);
    for (int p = 1; p < 17; p++) applyStimulus(1'b0, (p == 16) ? 8'h3C : 8'(p), 11'h000);
    applyStimulus(1'b0, 8'h9A, 11'h7FF);
    expectWrite(12'h1E4, 11'h7FF);
    waitIdle(1'b0, 300);
    checkOutput("resync_pulses_2", 32'(resyncCount), 32'd2);
    checkOutput("queue_drained_3", 32'(expQ.size()), 32'd0);

    // Finish the frame, then start a write and reset it mid-settle.
    applyStimulus(1'b0, 8'hF0, 11'h000);
    applyStimulus(1'b0, 8'h0F, 11'h010);
    expectWrite(12'h780, 11'h010);
    waitIdle(1'b0, 300);
    checkOutput("queue_drained_4", 32'(expQ.size()), 32'd0);
    for (int p = 0; p < 16; p++) applyStimulus(1'b0, 8'(p), 11'h000);
    applyStimulus(1'b0, 8'h01, 11'h000);
    applyStimulus(1'b0, 8'h02, 11'h005);
    repeat (10) @(negedge clk);
    checkOutput("busy_in_settle", 32'(busy), 32'd1);
    checkOutput("word_loaded", 32'(orbWord), 32'h008);
    rst = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(we), 32'd0);
    checkOutput("midrst_word", 32'(orbWord), 32'h0);
    checkOutput("midrst_addr", 32'(wrAddr), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_we", 32'(we), 32'd0);
    checkOutput("post_rst_no_resync", 32'(resyncCount), 32'd2);
    checkOutput("final_queue", 32'(expQ.size()), 32'd0);
    checkOutput("final_small_queue", 32'(expQ2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
